serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder controller. Sequences one full-adder cell, built from
//  two half_adder instances, across WIDTH clock cycles, LSB first.

---
 rtl/serial_adder_ctrl_pkg.sv | 16 +
 rtl/serial_adder_ctrl_fa.sv | 28 ++
 rtl/serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  // Bit counter width: enough to count 0..WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder assembled from two half adders and an OR for the carry.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  // The two half-adder carries can never both be high, so OR equals majority.
  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walked LSB first over WIDTH cycles,
// with a start/busy/done handshake and a result register held between operations.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [RW-1:0]    r_sh;
  logic [RW-1:0]    r_sh_next;
  logic [WIDTH-1:0] r_next;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s_bit;
  logic             c_next;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c),
    .s  (s_bit),
    .co (c_next)
  );

  // r_sh only needs the WIDTH-1 bits already produced; the current bit
  // completes the word in r_next, which is what lands in sum on the last step.
  assign r_next[WIDTH-1] = s_bit;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_rnext
      assign r_next[gi] = r_sh[gi];
    end
    if (WIDTH > 1) begin : g_rsh_wide
      assign r_sh_next = r_next[WIDTH-1:1];
    end else begin : g_rsh_one
      assign r_sh_next = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c     <= cin;
            r_sh  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_next;
          r_sh <= r_sh_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= r_next;
            cout  <= c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic       sum1;
  logic       cout1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted start yields a+b+cin exactly WIDTH edges later;
  // starts arriving while an add is outstanding are dropped.
  int         m_rem = 0;
  int         m_ops = 0;
  logic [8:0] m_pend = '0;
  logic [7:0] m_sum = '0;
  logic       m_cout = 1'b0;
  logic       m_done = 1'b0;
  int         dut_dones = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem  <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          {m_cout, m_sum} <= m_pend;
          m_done <= 1'b1;
          m_ops  <= m_ops + 1;
        end
      end else if (start8) begin
        m_pend <= {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
        m_rem  <= 8;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy8}, {31'd0, m_rem != 0});
    chk("done", {31'd0, done8}, {31'd0, m_done});
    chk("sum", {24'd0, sum8}, {24'd0, m_sum});
    chk("cout", {31'd0, cout8}, {31'd0, m_cout});
    if (done8) dut_dones++;
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     output int bcyc, output int dcyc);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    bcyc = 0;
    dcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done8) begin
        dcyc = i;
        break;
      end
      if (busy8) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tc, output int dcyc);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    dcyc = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done1) begin
        dcyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;
    int dc;
    int nd;
    int cyc;
    logic [8:0] res;
    logic [2:0] idx;
    int tt [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_sumcout", {23'd0, cout8, sum8}, 0);
    rst = 1'b0;
    @(negedge clk);

    // FF + 01: busy for 8 cycles, done in the 9th
    op8(8'hFF, 8'h01, 1'b0, bc, dc);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_done_cycle", dc, 9);
    chk("t1_result", {23'd0, cout8, sum8}, 32'h100);
    @(negedge clk);

    op8(8'h5A, 8'hA5, 1'b1, bc, dc);
    chk("t2a_result", {23'd0, cout8, sum8}, 32'h100);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_hold", {23'd0, cout8, sum8}, 32'h100);
    repeat (4) @(negedge clk);
    chk("t2b_done", {31'd0, done8}, 1);
    chk("t2b_result", {23'd0, cout8, sum8}, 32'h000);
    @(negedge clk);

    // a second start mid-run must be ignored
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00;
    nd = 0;
    res = '0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        nd++;
        res = {cout8, sum8};
      end
      @(negedge clk);
    end
    chk("t3_done_pulses", nd, 1);
    chk("t3_result", {23'd0, res}, 32'h046);

    // asynchronous reset part way through a run
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_busy_before", {31'd0, busy8}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_busy", {31'd0, busy8}, 0);
    chk("t4_done", {31'd0, done8}, 0);
    chk("t4_sumcout", {23'd0, cout8, sum8}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = dut_dones;
    @(negedge clk);
    chk("t4_no_done", dut_dones, nd);
    op8(8'h03, 8'h04, 1'b0, bc, dc);
    chk("t4_after", {23'd0, cout8, sum8}, 32'h007);
    chk("t4_after_done_cycle", dc, 9);
    @(negedge clk);

    // start held high: back-to-back operations every 9 cycles
    start8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a8 = 8'(k * 37 + 11); b8 = 8'(k * 91 + 200); cin8 = k[0];
      repeat (9) @(negedge clk);
      chk("t5_done", {31'd0, done8}, 1);
    end
    start8 = 1'b0;
    chk("t5_last", {23'd0, cout8, sum8}, {23'd0, 9'(4 * 37 + 11) % 256 + 9'(4 * 91 + 200) % 256});
    repeat (2) @(negedge clk);

    // WIDTH=1 truth table
    for (int k = 0; k < 8; k++) begin
      idx = 3'(k);
      op1(idx[2], idx[1], idx[0], dc);
      chk("t6_done_cycle", dc, 2);
      chk("t6_table", {30'd0, cout1, sum1}, tt[k]);
      chk("t6_arith", {30'd0, cout1, sum1}, {30'd0, 2'(idx[2]) + 2'(idx[1]) + 2'(idx[0])});
      @(negedge clk);
    end

    // random traffic checked by the model every cycle
    cyc = 0;
    nd = m_ops;
    while ((m_ops - nd) < 500 && cyc < 9000) begin
      start8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("rand_ops_reached", {31'd0, (m_ops - nd) >= 500}, 1);
    chk("done_count", dut_dones, m_ops);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
